// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: detects rising/falling edges on NUM_CH synchronous level
// inputs, queues each as a pending request, and offers them one at a time on a
// shared valid/ready port using round-robin arbitration.
//
// Ports:
//   CLK        clock
//   RSTN       synchronous reset, active low
//   SAMPLE_IN  level inputs, already synchronous to CLK
//   RISE_EN    per-channel rising-edge enable
//   FALL_EN    per-channel falling-edge enable
//   EVT_VALID  event offered
//   EVT_READY  consumer accepts event
//   EVT_ID     channel index of offered event
//   EVT_RISE   1 = rising edge, 0 = falling edge
//   OVF        sticky per-channel overflow flags
//   OVF_CLR    per-channel overflow clear pulse
module edge_event_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [NUM_CH-1:0]   SAMPLE_IN,
    input  logic [NUM_CH-1:0]   RISE_EN,
    input  logic [NUM_CH-1:0]   FALL_EN,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [ID_WIDTH-1:0] EVT_ID,
    output logic                EVT_RISE,
    output logic [NUM_CH-1:0]   OVF,
    input  logic [NUM_CH-1:0]   OVF_CLR
);

    localparam int unsigned REQ   = 2 * NUM_CH;
    localparam int unsigned PTR_W = $clog2(REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   fol_old_q, fol_new_q;
    logic [NUM_CH-1:0]   rise_c, fall_c;
    logic [REQ-1:0]      en_mask_c, req_set_c, grant_c;
    logic [REQ-1:0]      pend_q, pend_d;
    logic [NUM_CH-1:0]   ovf_set_c, ovf_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d, sel_c;
    logic                found_c;
    logic [31:0]         scan_idx_c;
    logic                valid_d;
    logic [ID_WIDTH-1:0] id_d;
    logic                rise_d;

    // Edge detection straight from the {old,new} follower pair
    assign rise_c = ~fol_old_q &  fol_new_q;
    assign fall_c =  fol_old_q & ~fol_new_q;

    // Requester r = 2*ch + (rise ? 0 : 1); overflow when an edge hits a still-pending, ungranted bit
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign en_mask_c[2*g]     = RISE_EN[g];
        assign en_mask_c[2*g+1]   = FALL_EN[g];
        assign req_set_c[2*g]     = rise_c[g] & RISE_EN[g];
        assign req_set_c[2*g+1]   = fall_c[g] & FALL_EN[g];
        assign ovf_set_c[g]       = |(req_set_c[2*g+1:2*g] & pend_q[2*g+1:2*g] & ~grant_c[2*g+1:2*g]);
    end

    // A new edge in the grant cycle re-arms the bit; a dropped enable wipes it
    assign pend_d = en_mask_c & ((pend_q & ~grant_c) | req_set_c);

    // Set wins over clear in the same cycle
    assign ovf_d  = (OVF & ~OVF_CLR) | ovf_set_c;

    // Round-robin scan: first pending requester at or above ptr, wrapping
    always_comb begin
        found_c    = 1'b0;
        sel_c      = '0;
        scan_idx_c = '0;
        for (int unsigned i = 0; i < REQ; i++) begin
            scan_idx_c = 32'(ptr_q) + i;
            if (scan_idx_c >= REQ) begin
                scan_idx_c = scan_idx_c - REQ;
            end
            if (!found_c && pend_q[scan_idx_c[PTR_W-1:0]]) begin
                found_c = 1'b1;
                sel_c   = scan_idx_c[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        valid_d = EVT_VALID;
        id_d    = EVT_ID;
        rise_d  = EVT_RISE;
        ptr_d   = ptr_q;
        grant_c = '0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_c[sel_c] = 1'b1;
                    valid_d        = 1'b1;
                    id_d           = ID_WIDTH'(sel_c >> 1);
                    rise_d         = ~sel_c[0];
                    ptr_d          = (32'(sel_c) == REQ - 1) ? '0 : sel_c + PTR_W'(1);
                    state_d        = OFFER;
                end
            end
            OFFER: begin
                if (EVT_READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, pointer and event port registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            EVT_VALID <= 1'b0;
            EVT_ID    <= '0;
            EVT_RISE  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            EVT_VALID <= valid_d;
            EVT_ID    <= id_d;
            EVT_RISE  <= rise_d;
        end
    end

    // Followers, pending bits and overflow flags
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fol_old_q <= '0;
            fol_new_q <= '0;
            pend_q    <= '0;
            OVF       <= '0;
        end else begin
            fol_old_q <= fol_new_q;
            fol_new_q <= SAMPLE_IN;
            pend_q    <= pend_d;
            OVF       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int NUM_CH   = 4;
    localparam int ID_WIDTH = 2;
    localparam int REQ      = 2 * NUM_CH;

    logic                CLK = 1'b0;
    logic                RSTN;
    logic [NUM_CH-1:0]   SAMPLE_IN;
    logic [NUM_CH-1:0]   RISE_EN;
    logic [NUM_CH-1:0]   FALL_EN;
    logic                EVT_VALID;
    logic                EVT_READY;
    logic [ID_WIDTH-1:0] EVT_ID;
    logic                EVT_RISE;
    logic [NUM_CH-1:0]   OVF;
    logic [NUM_CH-1:0]   OVF_CLR;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .ID_WIDTH(ID_WIDTH)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .SAMPLE_IN (SAMPLE_IN),
        .RISE_EN   (RISE_EN),
        .FALL_EN   (FALL_EN),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_ID    (EVT_ID),
        .EVT_RISE  (EVT_RISE),
        .OVF       (OVF),
        .OVF_CLR   (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: last two samples per channel, queued events per requester
    bit m_old  [NUM_CH];
    bit m_new  [NUM_CH];
    bit m_ovf  [NUM_CH];
    bit m_pend [REQ];
    bit m_valid;
    int m_id;
    bit m_rise;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int g;
        bit ovf_set [NUM_CH];
        if (!RSTN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_old[c] = 0; m_new[c] = 0; m_ovf[c] = 0;
            end
            for (int r = 0; r < REQ; r++) m_pend[r] = 0;
            m_valid = 0; m_id = 0; m_rise = 0; m_ptr = 0;
            return;
        end
        g = -1;
        if (!m_valid) begin
            for (int k = 0; k < REQ; k++) begin
                int r;
                r = (m_ptr + k) % REQ;
                if (g < 0 && m_pend[r]) g = r;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_id    = g / 2;
                m_rise  = (g % 2 == 0);
                m_ptr   = (g + 1) % REQ;
            end
        end else if (EVT_READY) begin
            m_valid = 0;
        end
        for (int c = 0; c < NUM_CH; c++) ovf_set[c] = 0;
        for (int r = 0; r < REQ; r++) begin
            int c;
            bit is_r, edg, en;
            c    = r / 2;
            is_r = (r % 2 == 0);
            edg  = is_r ? (!m_old[c] && m_new[c]) : (m_old[c] && !m_new[c]);
            en   = is_r ? RISE_EN[c] : FALL_EN[c];
            if (!en) begin
                m_pend[r] = 0;
            end else if (edg) begin
                if (m_pend[r] && r != g) ovf_set[c] = 1;
                m_pend[r] = 1;
            end else if (r == g) begin
                m_pend[r] = 0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_ovf[c] = ovf_set[c] || (m_ovf[c] && !OVF_CLR[c]);
            m_old[c] = m_new[c];
            m_new[c] = SAMPLE_IN[c];
        end
    endtask

    task automatic compare_model();
        logic [NUM_CH-1:0] exp_ovf;
        chk("valid", 32'(EVT_VALID), 32'(m_valid));
        if (m_valid) begin
            chk("id",   32'(EVT_ID),   32'(m_id));
            chk("rise", 32'(EVT_RISE), 32'(m_rise));
        end
        for (int c = 0; c < NUM_CH; c++) exp_ovf[c] = m_ovf[c];
        chk("ovf", 32'(OVF), 32'(exp_ovf));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_model();
    endtask

    initial begin
        int id3_seen;
        logic [NUM_CH-1:0] tg;
        int ci;

        // Reset and idle
        RSTN = 1'b0; SAMPLE_IN = '0; RISE_EN = '1; FALL_EN = '1;
        EVT_READY = 1'b0; OVF_CLR = '0;
        repeat (3) cycle();
        chk("rst_valid", 32'(EVT_VALID), 32'd0);
        chk("rst_id",    32'(EVT_ID),    32'd0);
        chk("rst_rise",  32'(EVT_RISE),  32'd0);
        chk("rst_ovf",   32'(OVF),       32'd0);
        RSTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_valid", 32'(EVT_VALID), 32'd0);
        end

        // Single rise then fall on channel 2
        EVT_READY = 1'b1;
        SAMPLE_IN = 4'b0100;
        cycle(); chk("sr_t0", 32'(EVT_VALID), 32'd0);
        cycle(); chk("sr_t1", 32'(EVT_VALID), 32'd0);
        cycle(); chk("sr_t2_valid", 32'(EVT_VALID), 32'd1);
        chk("sr_t2_id", 32'(EVT_ID), 32'd2);
        chk("sr_t2_rise", 32'(EVT_RISE), 32'd1);
        cycle(); chk("sr_t3", 32'(EVT_VALID), 32'd0);
        repeat (3) cycle();
        SAMPLE_IN = 4'b0000;
        cycle(); cycle();
        cycle(); chk("sf_valid", 32'(EVT_VALID), 32'd1);
        chk("sf_id", 32'(EVT_ID), 32'd2);
        chk("sf_rise", 32'(EVT_RISE), 32'd0);
        cycle(); chk("sf_drop", 32'(EVT_VALID), 32'd0);

        // Round-robin from a freshly reset pointer
        RSTN = 1'b0; cycle(); RSTN = 1'b1;
        SAMPLE_IN = 4'hF;
        cycle(); cycle();
        for (int k = 0; k < NUM_CH; k++) begin
            cycle();
            chk("rr_valid", 32'(EVT_VALID), 32'd1);
            chk("rr_id",    32'(EVT_ID),    32'(k));
            chk("rr_rise",  32'(EVT_RISE),  32'd1);
            cycle();
            chk("rr_gap", 32'(EVT_VALID), 32'd0);
        end
        FALL_EN = '0; SAMPLE_IN = '0;
        repeat (4) cycle();
        chk("fall_masked", 32'(EVT_VALID), 32'd0);
        FALL_EN = '1;
        repeat (2) cycle();
        SAMPLE_IN = 4'b1001;
        cycle(); cycle();
        cycle(); chk("wrap_first", 32'(EVT_ID), 32'd0);
        cycle();
        cycle(); chk("wrap_second", 32'(EVT_ID), 32'd3);
        cycle();

        // Backpressure and overflow on channel 1
        EVT_READY = 1'b0;
        SAMPLE_IN[1] = 1'b1; cycle();
        SAMPLE_IN[1] = 1'b0; cycle();
        SAMPLE_IN[1] = 1'b1; cycle();
        SAMPLE_IN[1] = 1'b0; cycle();
        SAMPLE_IN[1] = 1'b1; cycle();
        repeat (3) cycle();
        chk("bp_valid", 32'(EVT_VALID), 32'd1);
        chk("bp_id",    32'(EVT_ID),    32'd1);
        chk("bp_rise",  32'(EVT_RISE),  32'd1);
        chk("bp_ovf",   32'(OVF),       32'b0010);
        OVF_CLR = 4'b0010; cycle(); OVF_CLR = '0;
        chk("ovf_clr", 32'(OVF), 32'd0);
        SAMPLE_IN[1] = 1'b0; cycle();
        OVF_CLR = 4'b0010; cycle(); OVF_CLR = '0;
        chk("ovf_set_wins", 32'(OVF[1]), 32'd1);
        EVT_READY = 1'b1;
        repeat (12) cycle();

        // Enables: rise masked on channel 0, fall still reported
        SAMPLE_IN[0] = 1'b0;
        repeat (6) cycle();
        RISE_EN = 4'b1110;
        SAMPLE_IN[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rise_masked", 32'(EVT_VALID), 32'd0);
        end
        SAMPLE_IN[0] = 1'b0;
        cycle(); cycle();
        cycle(); chk("en_fall_valid", 32'(EVT_VALID), 32'd1);
        chk("en_fall_id",   32'(EVT_ID),   32'd0);
        chk("en_fall_rise", 32'(EVT_RISE), 32'd0);
        cycle();
        RISE_EN = '1;

        // Dropping FALL_EN discards an unserved pending fall on channel 3
        EVT_READY = 1'b0;
        SAMPLE_IN[1] = 1'b1;
        SAMPLE_IN[3] = 1'b0;
        repeat (3) cycle();
        FALL_EN[3] = 1'b0; cycle(); FALL_EN = '1;
        EVT_READY = 1'b1;
        id3_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (EVT_VALID && EVT_ID == 2'd3) id3_seen++;
        end
        chk("fall_discarded", 32'(id3_seen), 32'd0);

        // Reset in the middle of an offer
        EVT_READY = 1'b0;
        SAMPLE_IN[2] = 1'b1;
        repeat (3) cycle();
        chk("mid_offer_valid", 32'(EVT_VALID), 32'd1);
        RSTN = 1'b0; SAMPLE_IN = '0;
        cycle();
        chk("mid_rst_drop", 32'(EVT_VALID), 32'd0);
        RSTN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("no_stale", 32'(EVT_VALID), 32'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) tg[c] = ($urandom_range(3) == 0);
            SAMPLE_IN = SAMPLE_IN ^ tg;
            if ($urandom_range(31) == 0) begin
                ci = int'($urandom_range(NUM_CH - 1));
                RISE_EN[ci] = ~RISE_EN[ci];
            end
            if ($urandom_range(31) == 0) begin
                ci = int'($urandom_range(NUM_CH - 1));
                FALL_EN[ci] = ~FALL_EN[ci];
            end
            EVT_READY = ($urandom_range(9) < 6);
            for (int c = 0; c < NUM_CH; c++) OVF_CLR[c] = ($urandom_range(15) == 0);
            RSTN = ($urandom_range(499) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
